shift_cmd_queue: RTL and testbench

//  Command-side stage wrapped around the 8-bit barrel shifter. It buffers shift commands
//  {din, shamt, lr, al} from an upstream valid/ready source in a small FIFO. It presents the

---
 rtl/shift_pkg.sv | 28 ++
 rtl/cmd_fifo.sv | 70 +++++++
 rtl/shift_cmd_queue.sv | 93 +++++++++
 tb/tb_shift_cmd_queue.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared command layout for the shift command queue: field offsets and the packed command type.
// The packed struct order {al, lr, shamt, din} matches the offsets below.
package shift_pkg;

  localparam int CMD_W     = 13;
  localparam int DIN_LSB   = 0;
  localparam int SHAMT_LSB = 8;
  localparam int LR_BIT    = 11;
  localparam int AL_BIT    = 12;

  typedef struct packed {
    logic       al;
    logic       lr;
    logic [2:0] shamt;
    logic [7:0] din;
  } shift_cmd_t;

  function automatic shift_cmd_t make_cmd(input logic [7:0] din, input logic [2:0] shamt,
                                          input logic lr, input logic al);
    shift_cmd_t c;
    c.din   = din;
    c.shamt = shamt;
    c.lr    = lr;
    c.al    = al;
    return c;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Generic synchronous FIFO, head entry visible combinationally on pop_dat; full/empty from count.
// flush clears pointers and count and overrides any push or pop in the same cycle.
module cmd_fifo #(
  parameter int W     = 13,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  pop_dat,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign full    = (r_count == CNT_FULL);
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign pop_dat = r_mem[r_rd_ptr];

  assign w_push = push & ~full  & ~flush;
  assign w_pop  = pop  & ~empty & ~flush;

  // Storage needs no reset: an entry is only observed after it has been written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/shift_cmd_queue.sv
// Buffers shift commands, drives the external shifter from the FIFO head and registers its result.
// One-edge FIFO residency then one result per cycle; a stalled result blocks pops, never pushes.
module shift_cmd_queue
  import shift_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [7:0]    cmd_din,
  input  logic [2:0]    cmd_shamt,
  input  logic          cmd_lr,
  input  logic          cmd_al,
  output logic [7:0]    sh_din,
  output logic [2:0]    sh_shamt,
  output logic          sh_lr,
  output logic          sh_al,
  input  logic [7:0]    sh_dout,
  output logic          res_valid,
  output logic [7:0]    res_data,
  input  logic          res_ready,
  output logic [AW:0]   occupancy
);

  logic [CMD_W-1:0] w_cmd_in;
  logic [CMD_W-1:0] w_head_bits;
  shift_cmd_t       w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             r_res_valid;
  logic [7:0]       r_res_data;

  always_comb begin
    w_cmd_in                    = '0;
    w_cmd_in[DIN_LSB +: 8]      = cmd_din;
    w_cmd_in[SHAMT_LSB +: 3]    = cmd_shamt;
    w_cmd_in[LR_BIT]            = cmd_lr;
    w_cmd_in[AL_BIT]            = cmd_al;
  end

  // Ready depends only on fullness; there is no path from res_ready back to cmd_ready.
  assign cmd_ready = ~w_full;
  assign w_push    = cmd_valid & ~w_full;
  assign w_pop     = ~w_empty & (~r_res_valid | res_ready);

  cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (w_push),
    .push_dat (w_cmd_in),
    .pop      (w_pop),
    .pop_dat  (w_head_bits),
    .full     (w_full),
    .empty    (w_empty),
    .count    (occupancy)
  );

  assign w_head   = shift_cmd_t'(w_head_bits);
  assign sh_din   = w_empty ? 8'h00 : w_head.din;
  assign sh_shamt = w_empty ? 3'd0  : w_head.shamt;
  assign sh_lr    = w_empty ? 1'b0  : w_head.lr;
  assign sh_al    = w_empty ? 1'b0  : w_head.al;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= 8'h00;
    end else if (flush) begin
      r_res_valid <= 1'b0;
      r_res_data  <= 8'h00;
    end else if (w_pop) begin
      r_res_valid <= 1'b1;
      r_res_data  <= sh_dout;
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Bench for shift_cmd_queue: reference shifter on the sh_* ports, queue-level model, in-order scoreboard.
module tb_shift_cmd_queue;
  import shift_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_din;
  logic [2:0]    cmd_shamt;
  logic          cmd_lr;
  logic          cmd_al;
  logic [7:0]    sh_din;
  logic [2:0]    sh_shamt;
  logic          sh_lr;
  logic          sh_al;
  logic [7:0]    sh_dout;
  logic          res_valid;
  logic [7:0]    res_data;
  logic          res_ready;
  logic [AW:0]   occupancy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] shf(input logic [7:0] d, input logic [2:0] s,
                                     input logic lr, input logic al);
    logic signed [7:0] sd;
    sd = d;
    if (lr)      return d << s;
    else if (al) return sd >>> s;
    else         return d >> s;
  endfunction

  assign sh_dout = shf(sh_din, sh_shamt, sh_lr, sh_al);

  shift_cmd_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_din   (cmd_din),
    .cmd_shamt (cmd_shamt),
    .cmd_lr    (cmd_lr),
    .cmd_al    (cmd_al),
    .sh_din    (sh_din),
    .sh_shamt  (sh_shamt),
    .sh_lr     (sh_lr),
    .sh_al     (sh_al),
    .sh_dout   (sh_dout),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
    .occupancy (occupancy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a command queue of up to DEPTH entries plus one result slot.
  shift_cmd_t mq[$];
  logic       mv;
  logic [7:0] md;
  shift_cmd_t m_c;
  bit         m_can_push;
  bit         m_do_pop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mv = 1'b0;
      md = 8'h00;
    end else if (flush) begin
      mq.delete();
      mv = 1'b0;
      md = 8'h00;
    end else begin
      m_can_push = (mq.size() < DEPTH);
      m_do_pop   = (mq.size() > 0) && (!mv || res_ready);
      if (m_do_pop) begin
        m_c = mq.pop_front();
        md  = shf(m_c.din, m_c.shamt, m_c.lr, m_c.al);
        mv  = 1'b1;
      end else if (res_ready) begin
        mv = 1'b0;
      end
      if (cmd_valid && m_can_push) mq.push_back(make_cmd(cmd_din, cmd_shamt, cmd_lr, cmd_al));
    end
  end

  // Scoreboard of expected results in command order, independent of queue timing.
  logic [7:0] sb[$];
  logic [12:0] exp_sh;

  always @(negedge clk) begin
    #3;
    if (rst) begin
      sb.delete();
    end else begin
      chk("occupancy", 32'(occupancy), 32'(mq.size()));
      chk("cmd_ready", 32'(cmd_ready), 32'(mq.size() < DEPTH));
      chk("res_valid", 32'(res_valid), 32'(mv));
      if (mv) chk("res_data", 32'(res_data), 32'(md));
      exp_sh = (mq.size() > 0) ? mq[0] : 13'd0;
      chk("sh_bus", 32'({sh_al, sh_lr, sh_shamt, sh_din}), 32'(exp_sh));
      if (flush) begin
        sb.delete();
      end else begin
        if (res_valid && res_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_extra: got result %0h with no outstanding command", res_data);
          end else begin
            chk("sb_order", 32'(res_data), 32'(sb.pop_front()));
          end
        end
        if (cmd_valid && cmd_ready) sb.push_back(shf(cmd_din, cmd_shamt, cmd_lr, cmd_al));
      end
    end
  end

  task automatic set_cmd(input logic [7:0] d, input logic [2:0] s, input logic lr, input logic al);
    cmd_din   = d;
    cmd_shamt = s;
    cmd_lr    = lr;
    cmd_al    = al;
  endtask

  int got;
  int pushes;

  initial begin
    rst = 1'b1; flush = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
    set_cmd(8'h00, 3'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    // Reset mid-stream with three commands queued and a result pending.
    set_cmd(8'h11, 3'd1, 1'b1, 1'b0);
    cmd_valid = 1'b1;
    repeat (4) @(negedge clk);
    cmd_valid = 1'b0;
    chk("t1_occ", 32'(occupancy), 32'd3);
    chk("t1_res_valid", 32'(res_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t1_rst_occ", 32'(occupancy), 32'd0);
    chk("t1_rst_res_valid", 32'(res_valid), 32'd0);
    chk("t1_rst_res_data", 32'(res_data), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    #4;
    chk("t1_ready_after", 32'(cmd_ready), 32'd1);
    @(negedge clk);

    // Single arithmetic right shift.
    res_ready = 1'b1;
    set_cmd(8'h96, 3'd3, 1'b0, 1'b1);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t2_not_yet", 32'(res_valid), 32'd0);
    chk("t2_head_din", 32'(sh_din), 32'h96);
    @(negedge clk);
    chk("t2_valid", 32'(res_valid), 32'd1);
    chk("t2_data", 32'(res_data), 32'hF2);

    // Back-to-back commands, results on consecutive cycles.
    set_cmd(8'h96, 3'd3, 1'b0, 1'b0);
    cmd_valid = 1'b1;
    @(negedge clk);
    set_cmd(8'h96, 3'd2, 1'b1, 1'b0);
    @(negedge clk);
    chk("t3_r0", 32'({res_valid, res_data}), 32'h112);
    set_cmd(8'h80, 3'd7, 1'b0, 1'b1);
    @(negedge clk);
    chk("t3_r1", 32'({res_valid, res_data}), 32'h158);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("t3_r2", 32'({res_valid, res_data}), 32'h1FF);
    @(negedge clk);

    // Fill under backpressure, then drain in order.
    res_ready = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_cmd(8'(i + 1), 3'd0, 1'b0, 1'b0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("t4_occ", 32'(occupancy), 32'd4);
    chk("t4_ready", 32'(cmd_ready), 32'd0);
    chk("t4_res", 32'({res_valid, res_data}), 32'h101);
    res_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      if (res_valid) begin
        chk("t4_drain", 32'(res_data), 32'(got + 1));
        got++;
      end
      @(negedge clk);
    end
    chk("t4_drain_count", 32'(got), 32'd5);

    // Flush with queued commands, a pending result and a simultaneous push.
    res_ready = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_cmd(8'h40 + 8'(i), 3'd1, 1'b1, 1'b0);
      @(negedge clk);
    end
    chk("t5_occ_before", 32'(occupancy), 32'd2);
    chk("t5_rv_before", 32'(res_valid), 32'd1);
    set_cmd(8'hAA, 3'd1, 1'b0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    cmd_valid = 1'b0;
    chk("t5_occ", 32'(occupancy), 32'd0);
    chk("t5_rv", 32'(res_valid), 32'd0);
    chk("t5_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    chk("t5_discarded", 32'({res_valid, occupancy}), 32'd0);

    // Random valid/ready traffic.
    pushes = 0;
    for (int c = 0; c < 60000 && pushes < 10000; c++) begin
      cmd_valid = ($urandom_range(3) != 0);
      res_ready = ($urandom_range(3) != 0);
      set_cmd(8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
      if (cmd_valid && cmd_ready) pushes++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    chk("t6_pushes", 32'(pushes), 32'd10000);
    for (int c = 0; c < 20 && (occupancy != 0 || res_valid); c++) @(negedge clk);
    #4;
    chk("t6_drained", 32'({res_valid, occupancy}), 32'd0);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
